// File: rtl/pulse_to_level_pkg.sv
// Shared types and default parameters for the pulse-to-level handshake block.
package aes_hs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKLO = 2'd2
  } hs_state_t;

  localparam int CNT_W_DEFAULT    = 4;
  localparam int MIN_HIGH_DEFAULT = 2;

endpackage

// File: rtl/pulse_to_level_if.sv
// Event/handshake bundle between the event source, the consumer and pulse_to_level.
interface pulse_to_level_if
  import aes_hs_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             pulse_in;
  logic             ack_in;
  logic             clr_overflow;
  logic             req_out;
  logic             done;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  modport master (
    output pulse_in, ack_in, clr_overflow,
    input  req_out, done, pending, busy, overflow
  );

  modport slave (
    input  pulse_in, ack_in, clr_overflow,
    output req_out, done, pending, busy, overflow
  );

endinterface

// File: rtl/pulse_to_level_cnt.sv
// Saturating up/down counter; sat_hit flags an increment refused at full scale.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] r_q;

  assign sat_hit = inc & ~dec & (r_q == MAX_VAL);
  assign q       = r_q;

  // Simultaneous inc and dec cancel, so only a lone request moves the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (inc && !dec && (r_q != MAX_VAL)) begin
      r_q <= r_q + W'(1);
    end else if (dec && !inc && (r_q != '0)) begin
      r_q <= r_q - W'(1);
    end
  end

endmodule

// File: rtl/pulse_to_level.sv
// Turns single-cycle event pulses into a four-phase req/ack level handshake,
// queueing events that arrive while a handshake is in flight.
module pulse_to_level
  import aes_hs_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int MIN_HIGH = MIN_HIGH_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  pulse_to_level_if.slave bus
);

  localparam int                HOLD_W   = $clog2(MIN_HIGH + 1);
  localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(MIN_HIGH - 1);

  hs_state_t         r_state;
  logic              r_req;
  logic              r_done;
  logic              r_busy;
  logic              r_overflow;
  logic [HOLD_W-1:0] r_hold;

  logic [CNT_W-1:0]  w_pending;
  logic              w_sat_hit;
  logic              w_have_event;
  logic              w_launch;
  logic              w_hold_met;

  // A launch consumes either the arriving pulse or one queued event.
  assign w_have_event = bus.pulse_in | (w_pending != '0);
  assign w_launch     = w_have_event &
                        ((r_state == IDLE) | ((r_state == ACKLO) & ~bus.ack_in));
  assign w_hold_met   = (r_hold >= HOLD_MIN);

  sat_updown_cnt #(
    .W (CNT_W)
  ) u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (bus.pulse_in),
    .dec     (w_launch),
    .q       (w_pending),
    .sat_hit (w_sat_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state != IDLE) || (w_pending != '0);

      // A dropped event wins over a clear arriving in the same cycle.
      if (w_sat_hit) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_hold  <= '0;
          end
        end
        REQ: begin
          if (bus.ack_in && w_hold_met) begin
            r_state <= ACKLO;
            r_req   <= 1'b0;
          end else if (r_hold != HOLD_MIN) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        ACKLO: begin
          if (!bus.ack_in) begin
            r_done <= 1'b1;
            if (w_launch) begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_hold  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_out  = r_req;
  assign bus.done     = r_done;
  assign bus.pending  = w_pending;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed and random stimulus for pulse_to_level, checked each cycle against
// a behavioural model of the event queue and the req/ack handshake.
module tb_pulse_to_level;

  localparam int CNT_W    = 2;
  localparam int MIN_HIGH = 3;
  localparam int QMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pulse_to_level_if #(.CNT_W(CNT_W)) bus ();

  pulse_to_level #(
    .CNT_W    (CNT_W),
    .MIN_HIGH (MIN_HIGH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Model: event count waiting, request level, waiting-for-ack-low flag.
  int mQueue;
  bit mReq;
  bit mDraining;
  bit mDone;
  bit mOvf;
  bit mBusy;
  int mHighCycles;
  bit reqLag;

  function automatic void modelReset();
    mQueue      = 0;
    mReq        = 1'b0;
    mDraining   = 1'b0;
    mDone       = 1'b0;
    mOvf        = 1'b0;
    mBusy       = 1'b0;
    mHighCycles = 0;
  endfunction

  function automatic void modelStep(bit p, bit a, bit c);
    bit idle;
    bit ackLow;
    bit launch;
    bit letGo;
    int q;
    idle   = !mReq && !mDraining;
    ackLow = mDraining && !a;
    launch = (idle || ackLow) && (p || (mQueue > 0));
    letGo  = mReq && a && (mHighCycles >= MIN_HIGH);
    mBusy  = mReq || mDraining || (mQueue > 0);
    mDone  = ackLow;
    q = mQueue + int'(p) - int'(launch);
    if (q > QMAX) begin
      q    = QMAX;
      mOvf = 1'b1;
    end else if (c) begin
      mOvf = 1'b0;
    end
    mQueue = q;
    if (launch) begin
      mReq        = 1'b1;
      mDraining   = 1'b0;
      mHighCycles = 1;
    end else if (letGo) begin
      mReq      = 1'b0;
      mDraining = 1'b1;
    end else if (ackLow) begin
      mDraining = 1'b0;
    end else if (mReq) begin
      mHighCycles++;
    end
  endfunction

  task automatic checkOutput(string tag);
    logic [CNT_W-1:0] expPend;
    expPend = mQueue[CNT_W-1:0];
    assertCount++;
    assert (bus.req_out === mReq) else begin
      failCount++;
      $error("FAIL %s req_out: observed %0b expected %0b", tag, bus.req_out, mReq);
    end
    assertCount++;
    assert (bus.done === mDone) else begin
      failCount++;
      $error("FAIL %s done: observed %0b expected %0b", tag, bus.done, mDone);
    end
    assertCount++;
    assert (bus.pending === expPend) else begin
      failCount++;
      $error("FAIL %s pending: observed %0d expected %0d", tag, bus.pending, expPend);
    end
    assertCount++;
    assert (bus.busy === mBusy) else begin
      failCount++;
      $error("FAIL %s busy: observed %0b expected %0b", tag, bus.busy, mBusy);
    end
    assertCount++;
    assert (bus.overflow === mOvf) else begin
      failCount++;
      $error("FAIL %s overflow: observed %0b expected %0b", tag, bus.overflow, mOvf);
    end
  endtask

  task automatic applyStimulus(bit p, bit a, bit c, string tag);
    bit cur;
    @(negedge clk);
    checkOutput(tag);
    bus.pulse_in     = p;
    bus.ack_in       = a;
    bus.clr_overflow = c;
    cur = mReq;
    if (!rst_n) modelReset();
    else modelStep(p, a, c);
    reqLag = cur;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    checkOutput("reset");
    bus.pulse_in     = 1'b0;
    bus.ack_in       = 1'b0;
    bus.clr_overflow = 1'b0;
    rst_n            = 1'b1;
    modelStep(1'b0, 1'b0, 1'b0);
    reqLag = 1'b0;
  endtask

  task automatic asyncReset();
    @(negedge clk);
    checkOutput("preReset");
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkOutput("asyncReset");
    bus.pulse_in     = 1'b0;
    bus.ack_in       = 1'b0;
    bus.clr_overflow = 1'b0;
  endtask

  initial begin
    bit p;
    bit a;
    bit c;
    $display("[TB] pulse_to_level CNT_W=%0d MIN_HIGH=%0d", CNT_W, MIN_HIGH);
    rst_n            = 1'b0;
    bus.pulse_in     = 1'b0;
    bus.ack_in       = 1'b0;
    bus.clr_overflow = 1'b0;
    modelReset();
    reqLag = 1'b0;
    repeat (3) @(posedge clk);
    releaseReset();

    // Single event, consumer acks one cycle after req
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "idle");
    applyStimulus(1'b1, 1'b0, 1'b0, "single.pulse");
    repeat (12) applyStimulus(1'b0, reqLag, 1'b0, "single.follow");

    // Ack held high in IDLE is ignored
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, "idleAck");
    applyStimulus(1'b0, 1'b0, 1'b0, "idleAck.drop");

    // Immediate ack checks the minimum high time
    applyStimulus(1'b1, 1'b0, 1'b0, "hold.pulse");
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, "hold.ackHigh");
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "hold.ackLow");

    // Queue three events behind an active request, then drain
    applyStimulus(1'b1, 1'b0, 1'b0, "queue.launch");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, "queue.pulse");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, "queue.wait");
    repeat (40) applyStimulus(1'b0, reqLag, 1'b0, "queue.drain");

    // Pulse arriving on the same edge as a relaunch with one event queued
    applyStimulus(1'b1, 1'b0, 1'b0, "relaunch.launch");
    applyStimulus(1'b1, 1'b0, 1'b0, "relaunch.queue");
    for (int i = 0; i < 20 && !(mDraining && !reqLag); i++)
      applyStimulus(1'b0, reqLag, 1'b0, "relaunch.follow");
    applyStimulus(1'b1, 1'b0, 1'b0, "relaunch.pulse");
    repeat (30) applyStimulus(1'b0, reqLag, 1'b0, "relaunch.drain");

    // Overflow: consumer stalled, five pulses, then clear behaviour
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, "ovf.pulse");
    applyStimulus(1'b1, 1'b0, 1'b1, "ovf.clrWithDrop");
    applyStimulus(1'b0, 1'b0, 1'b0, "ovf.hold");
    applyStimulus(1'b0, 1'b0, 1'b1, "ovf.clr");
    repeat (40) applyStimulus(1'b0, reqLag, 1'b0, "ovf.drain");

    // Async reset in the middle of a request with two events queued
    applyStimulus(1'b1, 1'b0, 1'b0, "rst.launch");
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, "rst.queue");
    asyncReset();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, "rst.held");
    releaseReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, "rst.quiet");

    // Random traffic with a loosely cooperative consumer
    for (int i = 0; i < 800; i++) begin
      p = ($urandom_range(0, 3) == 0);
      if (mReq) a = $urandom_range(0, 1) != 0;
      else if (mDraining) a = ($urandom_range(0, 2) == 0);
      else a = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 9) == 0);
      applyStimulus(p, a, c, "random");
    end
    repeat (40) applyStimulus(1'b0, reqLag, 1'b0, "final.drain");
    @(negedge clk);
    checkOutput("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pulse_to_level.md
# pulse_to_level

Converts single-cycle event pulses, such as those from the core's edge detectors, into a registered four-phase req/ack level handshake toward a slower or multi-cycle consumer (e.g. AES key-load or block-start acceptance). Pulses that arrive while a handshake is in flight are queued in a saturating pending counter and replayed one handshake at a time. Loss is flagged by a sticky overflow bit.

## Interface
- CNT_W, 4: pending-counter width; queue depth 2^CNT_W − 1 events.
- MIN_HIGH, 2: minimum cycles req_out stays high per handshake (≥1).
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- pulse_in  input  1  one-cycle event. Every high cycle counts as one event.
- ack_in  input  1  consumer acknowledge, synchronous to clk.
- req_out  output  1  handshake request level, registered.
- done  output  1  one-cycle pulse when a handshake completes.
- pending  output  CNT_W  events accepted but not yet launched.
- busy  output  1  state ≠ IDLE or pending ≠ 0.
- overflow  output  1  sticky: an event was dropped.
- clr_overflow  input  1  synchronous clear of overflow.

## Operation
- States:
  - IDLE: req low.
  - REQ: req high.
  - ACKLO: req low, waiting for ack_in to drop.
- IDLE → REQ when pulse_in=1 or pending>0. The launch consumes one event.
- REQ → ACKLO when ack_in=1 and hold_cnt ≥ MIN_HIGH−1. hold_cnt clears on REQ entry and saturates.
- ACKLO, once ack_in=0:
  - done=1 for that cycle.
  - Go to REQ if pending>0 or pulse_in=1, consuming one event. Otherwise go to IDLE.
- Pending update each cycle, with inc = pulse_in and dec = launch:
  - inc & ~dec: pending+1.
  - dec & ~inc: pending−1.
  - Both set, or neither: pending unchanged.
  - A launch from a pulse_in with pending=0 is inc&dec, so pending stays 0.
- Saturation: inc & ~dec with pending = 2^CNT_W−1 leaves pending unchanged, drops the event, and sets overflow.
- overflow priority: set has priority over clr_overflow in the same cycle.
- ack_in high while in IDLE is ignored (no launch, no error).
- ack_in falling while in REQ is ignored. REQ exits only on ack_in=1.

## Timing
- Reset values, all asynchronous on rst_n=0: state=IDLE, req_out=0, done=0, pending=0, overflow=0, hold_cnt=0, busy=0.
- Reset mid-handshake: req_out drops immediately and the queue is discarded.
- First cycle after rst_n rises: block in IDLE.
- Latency: pulse_in at edge t (block idle) gives req_out=1 after edge t+1.
- req_out high time ≥ MIN_HIGH cycles.
- req_out falls on the edge after ack_in is sampled high (with the hold satisfied).
- req_out low time ≥ 1 cycle between handshakes: ACKLO is at least one cycle.
- done is registered. It is high in the cycle after the edge that samples ack_in=0 in ACKLO, i.e. coincident with the state leaving ACKLO.
- Back-to-back relaunch from ACKLO: req_out rises on the same edge that asserts done.
- busy and pending are registered. No combinational input→output paths.

## Structure
- Package aes_hs_pkg holds:
  - state enum hs_state_t {IDLE, REQ, ACKLO}, 2-bit encoding.
  - localparam default values for CNT_W and MIN_HIGH.
- One sub-module, sat_updown_cnt (parameter W). Ports inc, dec, q, sat_hit. Reused for pending.
- hold_cnt is inline, width $clog2(MIN_HIGH+1).

## Test plan
- Single event: reset, pulse_in at cycle 5, ack_in tied to req_out delayed 1 cycle → req_out high at cycles 6–7, done at cycle 10, pending stays 0, busy low from cycle 11.
- MIN_HIGH hold: MIN_HIGH=4, ack_in asserted the cycle after req rises → req_out high exactly 4 cycles.
- Queueing: 3 pulses during an active REQ → pending=3, then 3 further handshakes. pending decrements 3→2→1→0 at each launch. 4 done pulses total.
- Simultaneous pulse and launch: pulse_in in the same cycle as a relaunch from ACKLO with pending=1 → pending stays 1.
- Overflow: CNT_W=2, hold ack_in=0, send 5 pulses → pending saturates at 3, overflow=1. clr_overflow together with a dropped pulse → overflow stays 1. Lone clr_overflow → 0.
- Async reset: rst_n low mid-REQ with pending=2 → req_out, pending and busy are 0 before the next clk edge. After release, no request until a new pulse_in.
